// File: rtl/bus_io_responder.sv
// Memory-mapped I/O responder: a 4-register window on the CPU bus that bridges
// STO/LDA accesses to a TX FIFO (drained by a valid/ready sink) and an RX FIFO.
module bus_io_responder #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int BASE   = 28,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    inout  wire  [DWIDTH-1:0] data,
    output logic              hit,
    output logic              tx_valid,
    output logic [DWIDTH-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DWIDTH-1:0] rx_data,
    output logic              rx_ready
);
    localparam int         PW       = $clog2(DEPTH);
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [3:0]    tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d, rd_q, rd_d;

    logic [DWIDTH-1:0] tx_mem_q [DEPTH];
    logic [DWIDTH-1:0] rx_mem_q [DEPTH];

    logic [1:0]        offset;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              ctrl_wr, tx_push_req, tx_push, tx_pop, tx_flush;
    logic              rx_rd_sel, rx_end, rx_pop, rx_push, rx_flush, flag_clr;
    logic [DWIDTH-1:0] rd_mux;

    // BASE is a multiple of 4, so the low address bits are the register offset.
    assign hit    = ({1'b0, addr} >= (AWIDTH+1)'(BASE)) && ({1'b0, addr} <= (AWIDTH+1)'(BASE + 3));
    assign offset = addr[1:0];

    assign tx_empty = (tx_count_q == 4'd0);
    assign tx_full  = (tx_count_q == FULL_CNT);
    assign rx_empty = (rx_count_q == 4'd0);
    assign rx_full  = (rx_count_q == FULL_CNT);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign rx_ready = !rx_full && !rst;

    assign data = (rd && hit) ? rd_mux : {DWIDTH{1'bz}};

    always_comb begin
        rd_mux = '0;
        case (offset)
            2'd0:    rd_mux = DWIDTH'({2'b00, rx_udf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty});
            2'd1:    rd_mux = DWIDTH'({rx_count_q, tx_count_q});
            2'd2:    rd_mux = '0;
            default: rd_mux = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
        endcase
    end

    always_comb begin
        ctrl_wr     = wr && hit && (offset == 2'd1);
        tx_push_req = wr && hit && (offset == 2'd2);
        tx_flush    = ctrl_wr && data[0];
        rx_flush    = ctrl_wr && data[1];
        flag_clr    = ctrl_wr && data[2];
        // A pop in the same edge never makes room for a push into a full FIFO.
        tx_push     = tx_push_req && !tx_full;
        tx_pop      = tx_valid && tx_ready;
        rx_push     = rx_valid && rx_ready;
        // The RX head is consumed only once the read access ends, so it stays
        // stable on the bus however long the CPU holds rd.
        rx_rd_sel   = rd && hit && (offset == 2'd3);
        rx_end      = rd_q && !rx_rd_sel;
        rx_pop      = rx_end && !rx_empty;
        rd_d        = rx_rd_sel;

        tx_wptr_d  = tx_wptr_q + PW'(tx_push);
        tx_rptr_d  = tx_rptr_q + PW'(tx_pop);
        tx_count_d = tx_count_q + 4'(tx_push) - 4'(tx_pop);
        if (tx_flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end

        rx_wptr_d  = rx_wptr_q + PW'(rx_push);
        rx_rptr_d  = rx_rptr_q + PW'(rx_pop);
        rx_count_d = rx_count_q + 4'(rx_push) - 4'(rx_pop);
        if (rx_flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end

        tx_ovf_d = (tx_ovf_q && !flag_clr) || (tx_push_req && tx_full);
        rx_udf_d = (rx_udf_q && !flag_clr) || (rx_end && rx_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_udf_q   <= rx_udf_d;
            rd_q       <= rd_d;
        end
    end

    // Storage has no reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= data;
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    end
endmodule

// File: tb/tb_bus_io_responder.sv
// Directed bench for bus_io_responder: table of bus accesses plus hand-written
// sequences for TX drain, RX pop timing, underflow, full, and async reset.
module tb_bus_io_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] addr;
    logic       rd, wr;
    logic [7:0] drv;
    logic       drv_en;
    wire  [7:0] data;
    logic       hit, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0] tx_data, rx_data;

    int checks   = 0;
    int failures = 0;

    assign data = drv_en ? drv : 8'hzz;

    always #5 clk = ~clk;

    bus_io_responder #(.AWIDTH(5), .DWIDTH(8), .BASE(28), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data(data),
        .hit(hit), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    typedef struct {
        logic       is_wr;
        logic [4:0] a;
        logic [7:0] d;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wr = 1'b1; drv = d; drv_en = 1'b1;
        @(negedge clk);
        wr = 1'b0; drv_en = 1'b0;
        $display("WR addr=%0d data=%02h", a, d);
    endtask

    // Holds rd for 'hold' rising edges, checking the bus value on every cycle.
    task automatic bus_read(input logic [4:0] a, input int hold, input logic [7:0] exp, input string name);
        @(negedge clk);
        addr = a; rd = 1'b1;
        #1 check(name, data, exp);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            #1 check({name, "_held"}, data, exp);
        end
        @(negedge clk);
        $display("RD addr=%0d data=%02h hold=%0d", a, data, hold);
        rd = 1'b0;
    endtask

    task automatic rx_source(input logic [7:0] d);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        rx_valid = 1'b0;
        $display("RX push data=%02h", d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; addr = 5'd0; rd = 1'b0; wr = 1'b0; drv = 8'h00; drv_en = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // {is_wr, addr, write data or expected read data, name}
        vecs.push_back('{1'b0, 5'd28, 8'h05, "status_rst"});
        vecs.push_back('{1'b0, 5'd29, 8'h00, "ctrl_rst"});
        vecs.push_back('{1'b1, 5'd30, 8'hA1, "push_a1"});
        vecs.push_back('{1'b1, 5'd30, 8'hB2, "push_b2"});
        vecs.push_back('{1'b0, 5'd29, 8'h02, "ctrl_tx2"});
        vecs.push_back('{1'b0, 5'd30, 8'h00, "txdata_read"});
        vecs.push_back('{1'b1, 5'd30, 8'hC3, "push_c3"});
        vecs.push_back('{1'b1, 5'd30, 8'hD4, "push_d4"});
        vecs.push_back('{1'b0, 5'd28, 8'h06, "status_txfull"});
        vecs.push_back('{1'b1, 5'd30, 8'hE5, "push_over"});
        vecs.push_back('{1'b0, 5'd28, 8'h16, "status_ovf"});
        vecs.push_back('{1'b0, 5'd29, 8'h04, "ctrl_tx4"});
        vecs.push_back('{1'b1, 5'd29, 8'h04, "clr_flags"});
        vecs.push_back('{1'b0, 5'd28, 8'h06, "status_clr"});
        vecs.push_back('{1'b1, 5'd29, 8'h01, "flush_tx"});
        vecs.push_back('{1'b0, 5'd28, 8'h05, "status_flush"});
        vecs.push_back('{1'b0, 5'd31, 8'h00, "rx_empty_rd"});
        vecs.push_back('{1'b0, 5'd28, 8'h25, "status_udf"});
        vecs.push_back('{1'b0, 5'd29, 8'h00, "ctrl_udf"});
        vecs.push_back('{1'b1, 5'd29, 8'h04, "clr_udf"});
        vecs.push_back('{1'b0, 5'd28, 8'h05, "status_udf_clr"});
        vecs.push_back('{1'b1, 5'd27, 8'hAA, "write_outside"});
        vecs.push_back('{1'b0, 5'd29, 8'h00, "ctrl_outside"});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("tx_valid_rst", tx_valid, 1'b0);
        check("rx_ready_rst", rx_ready, 1'b1);
        check("hit_addr0", hit, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_write(vecs[i].a, vecs[i].d);
            else               bus_read(vecs[i].a, 1, vecs[i].d, vecs[i].name);
        end

        // TX drain through the sink handshake.
        bus_write(5'd30, 8'hA1);
        bus_write(5'd30, 8'hB2);
        #1;
        check("tx_valid_loaded", tx_valid, 1'b1);
        check("tx_head_a1", tx_data, 8'hA1);
        tx_ready = 1'b1;
        @(negedge clk); #1;
        check("tx_head_b2", tx_data, 8'hB2);
        check("tx_valid_one", tx_valid, 1'b1);
        @(negedge clk); #1;
        check("tx_valid_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;
        $display("TX drained");

        // RX fill, then a 3-cycle read yields one stable byte and one pop.
        rx_source(8'h3C);
        rx_source(8'h7E);
        bus_read(5'd29, 1, 8'h20, "ctrl_rx2");
        bus_read(5'd31, 3, 8'h3C, "rx_read_3c");
        bus_read(5'd29, 1, 8'h10, "ctrl_rx1");

        // Push lands on the same edge as the pop: count unchanged.
        rx_source(8'h11);
        bus_read(5'd31, 3, 8'h7E, "rx_read_7e");
        rx_valid = 1'b1; rx_data = 8'h22;
        @(negedge clk);
        rx_valid = 1'b0;
        bus_read(5'd29, 1, 8'h20, "ctrl_simul");
        bus_read(5'd31, 1, 8'h11, "rx_read_11");
        bus_read(5'd31, 2, 8'h22, "rx_read_22");
        bus_read(5'd29, 1, 8'h00, "ctrl_rx_empty");

        // RX full: rx_ready drops, extra byte refused, then flush.
        rx_source(8'h01);
        rx_source(8'h02);
        rx_source(8'h03);
        rx_source(8'h04);
        #1 check("rx_ready_full", rx_ready, 1'b0);
        rx_source(8'h05);
        bus_read(5'd28, 1, 8'h09, "status_rxfull");
        bus_read(5'd29, 1, 8'h40, "ctrl_rx4");
        bus_read(5'd31, 1, 8'h01, "rx_head_full");
        bus_write(5'd29, 8'h02);
        bus_read(5'd28, 1, 8'h05, "status_rxflush");

        // Asynchronous reset away from any clock edge with TX loaded.
        bus_write(5'd30, 8'h10);
        bus_write(5'd30, 8'h20);
        bus_write(5'd30, 8'h30);
        rx_source(8'h55);
        #1 check("tx_valid_pre_rst", tx_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("tx_valid_async_rst", tx_valid, 1'b0);
        check("rx_ready_in_rst", rx_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        $display("async reset pulse done");
        bus_read(5'd28, 1, 8'h05, "status_post_rst");
        bus_read(5'd29, 1, 8'h00, "ctrl_post_rst");

        @(negedge clk);
        addr = 5'd27; #1 check("hit_addr27", hit, 1'b0);
        addr = 5'd28; #1 check("hit_addr28", hit, 1'b1);
        addr = 5'd31; #1 check("hit_addr31", hit, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
